// File: rtl/rf68851_pkg.sv
// Shared types and grant encodings for the MMU memory-side bus arbiter.
package rf68851_pkg;

   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [2:0]  fc;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
   } bus_req_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_TOUT  = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_e;

   localparam logic [1:0] GNT_WALK = 2'd0;
   localparam logic [1:0] GNT_CPU  = 2'd1;
   localparam logic [1:0] GNT_DMA  = 2'd2;
   localparam logic [1:0] GNT_NONE = 2'd3;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Stalled-strobe watchdog: counts wait cycles, expires on the cycle that would reach TIMEOUT.
module bus_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   logic [7:0] r_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)     r_cnt <= 8'd0;
      else if (i_clr) r_cnt <= 8'd0;
      else if (i_en)  r_cnt <= r_cnt + 8'd1;
   end

   // An ack in the same cycle clears instead, so it always beats the timeout.
   assign o_expired = i_en && !i_clr && (r_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mmu_bus_arb.sv
// Three-master memory bus arbiter: walker fixed priority, CPU/DMA round-robin, lock while cyc held.
// Define ARB_TIMEOUT_EN to build the bus-timeout watchdog (TOUT/DRAIN states, tout_o).
import rf68851_pkg::*;

module mmu_bus_arb #(
   parameter int TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [2:0]       req_cyc_i,
   input  logic [2:0]       req_stb_i,
   input  logic [2:0]       req_we_i,
   input  logic [2:0][2:0]  req_fc_i,
   input  logic [2:0][3:0]  req_sel_i,
   input  logic [2:0][31:0] req_adr_i,
   input  logic [2:0][31:0] req_dat_i,
   output logic [2:0]       req_ack_o,
   output logic [2:0]       req_err_o,
   output logic [31:0]      req_dat_o,
   output logic [2:0]       mfc_o,
   output logic             mcyc_o,
   output logic             mstb_o,
   output logic             mwe_o,
   output logic [3:0]       msel_o,
   output logic [31:0]      madr_o,
   output logic [31:0]      mdat_o,
   input  logic             mack_i,
   input  logic             merr_i,
   input  logic [31:0]      mdat_i,
   output logic [1:0]       gnt_o,
   output logic             tout_o
);

   bus_req_t   w_req [3];
   bus_req_t   w_own;
   arb_state_e r_state, w_state_nxt;
   logic [1:0] r_gnt, w_gnt_nxt;
   logic       r_rr, w_rr_nxt;
   logic [2:0] w_gnt_oh;
   logic       w_bus_on;
   logic       w_expired;

   for (genvar i = 0; i < 3; i++) begin : g_req
      assign w_req[i] = '{cyc: req_cyc_i[i], stb: req_stb_i[i], we: req_we_i[i],
                          fc: req_fc_i[i], sel: req_sel_i[i], adr: req_adr_i[i],
                          dat: req_dat_i[i]};
   end

   always_comb begin
      w_own = '0;
      case (r_gnt)
         GNT_WALK: w_own = w_req[0];
         GNT_CPU:  w_own = w_req[1];
         GNT_DMA:  w_own = w_req[2];
         default:  w_own = '0;
      endcase
   end

   assign w_gnt_oh = (r_gnt == GNT_NONE) ? 3'b000 : (3'b001 << r_gnt);

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_rr_nxt    = r_rr;
      case (r_state)
         ST_IDLE: begin
            if (|req_cyc_i) begin
               w_state_nxt = ST_OWN;
               if (req_cyc_i[0]) begin
                  w_gnt_nxt = GNT_WALK;
               end else if (req_cyc_i[1] && (!r_rr || !req_cyc_i[2])) begin
                  w_gnt_nxt = GNT_CPU;
                  w_rr_nxt  = 1'b1;
               end else begin
                  w_gnt_nxt = GNT_DMA;
                  w_rr_nxt  = 1'b0;
               end
            end
         end
         ST_OWN: begin
            if (!w_own.cyc) begin
               w_state_nxt = ST_IDLE;
               w_gnt_nxt   = GNT_NONE;
            end else if (w_expired) begin
               w_state_nxt = ST_TOUT;
            end
         end
         ST_TOUT: w_state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (!w_own.cyc) begin
               w_state_nxt = ST_IDLE;
               w_gnt_nxt   = GNT_NONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = GNT_NONE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_IDLE;
         r_gnt   <= GNT_NONE;
         r_rr    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_rr    <= w_rr_nxt;
      end
   end

   // Bus is driven only in OWN; TOUT and DRAIN keep it idle and swallow late acks.
   assign w_bus_on  = (r_state == ST_OWN);
   assign mcyc_o    = w_bus_on & w_own.cyc;
   assign mstb_o    = w_bus_on & w_own.stb;
   assign mwe_o     = w_bus_on & w_own.we;
   assign mfc_o     = w_bus_on ? w_own.fc  : 3'd0;
   assign msel_o    = w_bus_on ? w_own.sel : 4'd0;
   assign madr_o    = w_bus_on ? w_own.adr : 32'd0;
   assign mdat_o    = w_bus_on ? w_own.dat : 32'd0;
   assign req_ack_o = w_bus_on ? (w_gnt_oh & {3{mack_i}}) : 3'b000;
   assign req_err_o = w_bus_on ? (w_gnt_oh & {3{merr_i}}) :
                      (r_state == ST_TOUT) ? w_gnt_oh : 3'b000;
   assign req_dat_o = (r_gnt != GNT_NONE) ? mdat_i : 32'd0;
   assign gnt_o     = r_gnt;

`ifdef ARB_TIMEOUT_EN
   assign tout_o = (r_state == ST_TOUT);

   bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tout (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_clr     (!w_bus_on | mack_i | merr_i),
      .i_en      (w_bus_on & w_own.stb),
      .o_expired (w_expired)
   );
`else
   logic w_unused_tout;
   assign w_unused_tout = ^8'(TIMEOUT);
   assign tout_o        = 1'b0;
   assign w_expired     = 1'b0;
`endif

endmodule
